// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared FSM state type and nibble width for the nibble serial adder
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - stateless 4-bit gate-level ripple adder exposing the carry into bit 3
module nibble_add
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = ci;

  // One full adder per bit; carries ripple upward through w_c.
  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
    assign s[gi]     = x[gi] ^ y[gi] ^ w_c[gi];
    assign w_c[gi+1] = (x[gi] & y[gi]) | (w_c[gi] & (x[gi] ^ y[gi]));
  end

  assign co = w_c[NIBBLE_W];
  assign c3 = w_c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder processing one nibble per clock; NSA_OVERFLOW_EN adds the ovf output
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef NSA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic [NIBBLE_W-1:0] w_x;
  logic [NIBBLE_W-1:0] w_y;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_co;
`ifdef NSA_OVERFLOW_EN
  logic                w_c3;
  logic                r_ovf;
`else
  logic                w_c3_unused;
`endif

  assign w_x = r_a[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
  assign w_y = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];

  nibble_add u_nibble_add (
    .x  (w_x),
    .y  (w_y),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co),
`ifdef NSA_OVERFLOW_EN
    .c3 (w_c3)
`else
    .c3 (w_c3_unused)
`endif
  );

  // Sequencer: capture operands on start, add one nibble per RUN cycle, pulse DONE once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
`ifdef NSA_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*NIBBLE_W +: NIBBLE_W] <= w_s;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_co;
`ifdef NSA_OVERFLOW_EN
            r_ovf   <= w_c3 ^ w_co;
`endif
            r_idx   <= '0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef NSA_OVERFLOW_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=4
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  wire         busy;
  wire         done;
  wire  [15:0] sum;
  wire         cout;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        cin4;
  wire         busy4;
  wire         done4;
  wire  [3:0]  sum4;
  wire         cout4;

`ifdef NSA_OVERFLOW_EN
  wire         ovf;
  wire         ovf4;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef NSA_OVERFLOW_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
`ifdef NSA_OVERFLOW_EN
    .ovf   (ovf4),
`endif
    .cout  (cout4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; overflow when equal-sign operands give a different-sign sum.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                      input bit inject, input string tag);
    logic [16:0] full;
    logic        exp_ovf;
    logic [15:0] held_sum;
    int          lat;
    int          busy_cnt;
    int          extra_done;
    full    = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
    exp_ovf = (ta[15] == tb_[15]) && (full[15] != ta[15]);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (inject && lat == 1) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(sum), 64'(full[15:0]));
    chk({tag, "_cout"}, 64'(cout), 64'(full[16]));
`ifdef NSA_OVERFLOW_EN
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
    held_sum = sum;
    @(posedge clk); #1;
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd5);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_sum_hold"}, 64'(sum), 64'(held_sum));
    if (inject) begin
      extra_done = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra_done++;
      end
      chk({tag, "_extra_done"}, 64'(extra_done), 64'd0);
      chk({tag, "_sum_after"}, 64'(sum), 64'(full[15:0]));
    end
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc, input string tag);
    logic [4:0] full;
    int         lat;
    full = {1'b0, ta} + {1'b0, tb_} + {4'd0, tc};
    @(negedge clk);
    a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (done4 !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd1);
    chk({tag, "_sum"}, 64'(sum4), 64'(full[3:0]));
    chk({tag, "_cout"}, 64'(cout4), 64'(full[4]));
    @(posedge clk); #1;
    chk({tag, "_done_low"}, 64'(done4), 64'd0);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
`ifdef NSA_OVERFLOW_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ffff_p1");
    chk("ffff_p1_sum_const", 64'(sum), 64'h0000);
    op16(16'h1234, 16'h4321, 1'b1, 1'b0, "b2b_first");
    chk("b2b_first_const", 64'(sum), 64'h5556);
    op16(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, "b2b_second");
    op16(16'h0F0F, 16'h0101, 1'b1, 1'b1, "ignore_start");

    // Asynchronous reset after two nibbles have been processed.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
`ifdef NSA_OVERFLOW_EN
    chk("abort_ovf", 64'(ovf), 64'd0);
`endif
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op16(16'hABCD, 16'h1111, 1'b1, 1'b0, "after_abort");

    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_pos");
    chk("ovf_pos_sum_const", 64'(sum), 64'h8000);
`ifdef NSA_OVERFLOW_EN
    chk("ovf_pos_flag_const", 64'(ovf), 64'd1);
`endif
    op16(16'h8000, 16'h8000, 1'b0, 1'b0, "ovf_neg");
    op16(16'h0000, 16'h0000, 1'b0, 1'b0, "zero");
    op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "all_ones");

    for (int i = 0; i < 20; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, $sformatf("rnd16_%0d", i));
    end

    op4(4'h9, 4'h8, 1'b1, "w4_dir");
    chk("w4_dir_sum_const", 64'(sum4), 64'h2);
    for (int i = 0; i < 8; i++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("rnd4_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, captured when start is accepted.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port sum, output, WIDTH bits: registered result.
REQ-011 SHALL have port cout, output, 1 bit: registered final carry-out.
REQ-012 SHALL have port ovf, output, 1 bit: registered signed overflow; present only under NSA_OVERFLOW_EN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start in IDLE at edge E0: capture a, b and cin; clear sum, cout and ovf; set nibble index to 0; go to RUN.
REQ-015 SHALL, on each RUN edge, add nibble[idx] of A and B to the carry register, write the 4-bit result into sum[4*idx+3:4*idx], update the carry register, and increment idx.
REQ-016 SHALL, on the edge that processes nibble N-1 (N = WIDTH/4): load cout from the final carry, go to DONE and assert done.
REQ-017 SHALL therefore raise done exactly N cycles after E0, for example 4 cycles when WIDTH=16 and 1 cycle when WIDTH=4.
REQ-018 SHALL go from DONE to IDLE on the next edge and deassert done there; done SHALL be high for exactly one cycle.
REQ-019 SHALL ignore start while busy=1 (RUN or DONE); captured operands SHALL be unaffected.
REQ-020 SHALL treat a and b changes after E0 as don't-care.
REQ-021 SHALL hold sum, cout and ovf stable from done until the next accepted start.
REQ-022 SHALL compute results modulo 2^WIDTH, with the carry out of bit WIDTH-1 on cout.
REQ-023 SHALL accept start asserted in the IDLE cycle right after DONE, giving back-to-back operations with a one-cycle IDLE gap.

Reset
REQ-024 SHALL, when rst_n is low (asynchronously, at any time including mid-RUN): state=IDLE, idx=0, carry=0, busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-025 SHALL leave IDLE only after a start sampled on a rising edge with rst_n high; a reset-aborted operation SHALL produce no done.

Configuration
REQ-026 SHALL use macro NSA_OVERFLOW_EN.
REQ-027 SHALL, when NSA_OVERFLOW_EN is defined: provide port ovf, loaded on the last RUN edge with (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), where the carry into bit WIDTH-1 comes from the sub-module.
REQ-028 SHALL, when NSA_OVERFLOW_EN is undefined: omit the ovf port and its logic; all other behaviour SHALL be identical.

Structure
REQ-029 SHALL place in shared package nsa_pkg: the FSM state enum (IDLE, RUN, DONE) and constant NIBBLE_W=4.
REQ-030 SHALL instantiate exactly one combinational sub-module nibble_add (4-bit gate-level ripple adder): inputs x[3:0], y[3:0], ci; outputs s[3:0], co, c3 (carry into bit 3).
REQ-031 SHALL implement all sequencing, index counting and registers in nibble_serial_adder; nibble_add SHALL hold no state.

Verification (WIDTH=16 unless stated)
REQ-032 SHALL pass: a=FFFF, b=0001, cin=0, start → done 4 cycles after E0, sum=0000, cout=1, busy high 5 cycles.
REQ-033 SHALL pass: a=1234, b=4321, cin=1 → sum=5556, cout=0; a second start the cycle after done → second result correct.
REQ-034 SHALL pass: start pulsed during RUN with different a/b → ignored, first result unchanged, only one done pulse.
REQ-035 SHALL pass: rst_n low during RUN after 2 nibbles → all outputs 0 immediately, no done; a later start completes normally.
REQ-036 SHALL pass, with NSA_OVERFLOW_EN: a=7FFF, b=0001 → sum=8000, ovf=1, cout=0; a=FFFF, b=0001 → ovf=0.
REQ-037 SHALL pass: WIDTH=4, a=9, b=8, cin=1 → done 1 cycle after E0, sum=2, cout=1.
